// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux round-robin multiplexer.
package arb_mux_pkg;

  localparam int ARB_MUX_MAX_N = 16;

  // Channel-index width; never below 1 so a single-channel build still has a port.
  function automatic int selw_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: double-width masked priority search
// starting at ptr and wrapping modulo N. Produces one-hot grant and its index.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = selw_f(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [2*N-1:0] req_dbl;
  logic           hit;

  // Search the doubled request vector from bit ptr upward; the upper copy
  // covers the wrap-around, so the first hit is the round-robin winner.
  always_comb begin
    req_dbl   = {req, req};
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (!hit && req_dbl[i] && (i >= int'(ptr))) begin
        hit              = 1'b1;
        grant_idx        = SELW'(i % N);
        grant[i % N]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with round-robin arbitration and one
// registered output stage. Optional burst locking via ARB_MUX_LOCK_EN
// (adds in_last; a channel keeps the grant until its last beat transfers).
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = selw_f(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [SELW-1:0] ptr_q;
  logic [N-1:0]    req_eff;
  logic [SELW-1:0] ptr_eff;
  logic [N-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic            load;
  logic            xfer;

`ifdef ARB_MUX_LOCK_EN
  logic            lock_q;
  logic [SELW-1:0] lock_idx_q;
  logic [N-1:0]    lock_mask;

  // While locked only the owning channel may request, and the search starts at it.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_idx_q] = 1'b1;
    req_eff              = lock_q ? (in_valid & lock_mask) : in_valid;
    ptr_eff              = lock_q ? lock_idx_q : ptr_q;
  end
`else
  assign req_eff = in_valid;
  assign ptr_eff = ptr_q;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req       (req_eff),
    .ptr       (ptr_eff),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer     = |in_ready;

  // Output register and round-robin pointer; a stalled beat holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_q     <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_sel  <= gidx;
`ifdef ARB_MUX_LOCK_EN
        if (in_last[gidx])
          ptr_q <= (gidx == SELW'(N-1)) ? '0 : gidx + 1'b1;
`else
        ptr_q <= (gidx == SELW'(N-1)) ? '0 : gidx + 1'b1;
`endif
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  // Burst lock: set on a non-last beat, cleared on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (xfer) begin
      lock_q     <= !in_last[gidx];
      lock_idx_q <= gidx;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux (N=4, WIDTH=32).
module tb_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".sel"},   64'(out_sel),   64'(s));
    chk({tag, ".data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);

    // Reset held for two edges with every channel requesting
    tick(); tick();
    chk("rst.in_ready", 64'(in_ready), 64'h0);
    chk_out("rst", 1'b0, 2'd0, 32'h0);

    // Round robin, all four channels valid
    rst = 1'b0; #1;
    chk("rr.ready0", 64'(in_ready), 64'h1);
    tick(); chk_out("rr0", 1'b1, 2'd0, 32'hA0);
    chk("rr.ready1", 64'(in_ready), 64'h2);
    tick(); chk_out("rr1", 1'b1, 2'd1, 32'hA1);
    tick(); chk_out("rr2", 1'b1, 2'd2, 32'hA2);
    tick(); chk_out("rr3", 1'b1, 2'd3, 32'hA3);
    tick(); chk_out("rr4", 1'b1, 2'd0, 32'hA0);
    tick(); chk_out("rr5", 1'b1, 2'd1, 32'hA1);
    tick(); chk_out("rr6", 1'b1, 2'd2, 32'hA2);

    // Backpressure after channel 2 loads
    out_ready = 1'b0; #1;
    chk("bp.ready", 64'(in_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("bp.hold", 1'b1, 2'd2, 32'hA2);
      chk("bp.ready_hold", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1; #1;
    chk("bp.release", 64'(in_ready), 64'h8);
    tick(); chk_out("bp.next", 1'b1, 2'd3, 32'hA3);

    // Sparse requests: bring pointer to 2 via channel 1, then channels 1 and 3
    in_valid = 4'b0010;
    tick(); chk_out("sp.ch1", 1'b1, 2'd1, 32'hA1);
    in_valid = 4'b1010; #1;
    chk("sp.ready3", 64'(in_ready), 64'h8);
    tick(); chk_out("sp.first", 1'b1, 2'd3, 32'hA3);
    chk("sp.ready1", 64'(in_ready), 64'h2);
    tick(); chk_out("sp.second", 1'b1, 2'd1, 32'hA1);
    in_valid = 4'b0000;
    tick(); chk_out("sp.idle", 1'b0, 2'd1, 32'hA1);

    // Simultaneous drain and load
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick(); chk_out("dl.load", 1'b1, 2'd0, 32'hA0);
    chk("dl.stall", 64'(in_ready), 64'h0);
    in_data[0 +: W] = 32'hB0;
    out_ready = 1'b1; #1;
    chk("dl.ready", 64'(in_ready), 64'h1);
    tick(); chk_out("dl.nobubble", 1'b1, 2'd0, 32'hB0);

    // Reset mid-transfer drops the held beat
    out_ready = 1'b0;
    rst = 1'b1;
    tick(); chk_out("mrst", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    in_data[0 +: W] = 32'hA0;

    // Channel 0 once to move the pointer to 1, then channels 0 and 1 together
    in_valid = 4'b0001;
    in_last  = 4'hF;
    tick(); chk_out("lk.pre", 1'b1, 2'd0, 32'hA0);
    in_valid = 4'b0011;
    in_last  = 4'b1101;
`ifdef ARB_MUX_LOCK_EN
    tick(); chk_out("lk.b0", 1'b1, 2'd1, 32'hA1);
    chk("lk.ready", 64'(in_ready), 64'h2);
    tick(); chk_out("lk.b1", 1'b1, 2'd1, 32'hA1);
    in_last = 4'b1111;
    tick(); chk_out("lk.b2", 1'b1, 2'd1, 32'hA1);
    tick(); chk_out("lk.after", 1'b1, 2'd0, 32'hA0);
`else
    tick(); chk_out("nl.b0", 1'b1, 2'd1, 32'hA1);
    chk("nl.ready", 64'(in_ready), 64'h1);
    tick(); chk_out("nl.b1", 1'b1, 2'd0, 32'hA0);
    tick(); chk_out("nl.b2", 1'b1, 2'd1, 32'hA1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes, round-robin arbitration and one registered output stage.
- Replaces hand-wired select muxes where several producers share one consumer port, e.g. memory/MMIO request merging or debug-bus sharing in the CPU datapath.
- Select is generated internally by the arbiter, not supplied by the caller; the granted channel index is reported with the data.

Parameters:
- WIDTH, 32, payload width in bits.
- N, 4, number of input channels; legal range 1..16.
- SELW, $clog2(N) (minimum 1), localparam; width of the channel index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel request valid.
- in_data  input  N*WIDTH  flattened payloads; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; combinational.
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered payload.
- out_sel  output  SELW  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_sel=0, priority pointer=0 (channel 0 has highest priority first). Reset mid-transfer drops any held beat. in_ready is 0 while rst=1.
- load = !out_valid || out_ready, combinational.
- Grant: one-hot over in_valid. Search starts at the pointer and wraps modulo N; the first channel with in_valid=1 wins. With no requests, grant=0.
- in_ready[i] = load && grant[i] && !rst. At most one bit of in_ready is set. An input beat transfers when in_valid[i] && in_ready[i].
- On a transfer:
  - out_data <= in_data[grant], out_sel <= grant index, out_valid <= 1.
  - pointer <= (grant index + 1) mod N.
- If load=1 and there is no request: out_valid <= 0, and out_data/out_sel hold their previous values.
- If out_valid=1 and out_ready=0: out_data, out_sel and the pointer hold, and every in_ready is 0.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one beat per cycle when out_ready is held high.
- Simultaneous out_ready and a new request: the held beat leaves and the new beat loads in the same edge, so there is no bubble.
- Requests that change while a channel is not granted are legal. Producers keep valid and data stable until accepted, but the arbiter does not depend on this.
- N=1: the arbiter degenerates, out_sel is always 0, and the block behaves as a one-entry pipeline register.
- Fairness: with all N channels requesting continuously, each channel is granted exactly once every N transfers.

Optional Feature:
- Macro: ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_last (N bits), marking the final beat of a multi-beat burst per channel.
  - After a transfer from channel k with in_last[k]=0, the grant is locked to k. The pointer does not advance and other channels see in_ready=0.
  - The lock releases on the transfer where in_last[k]=1; the pointer then advances to k+1.
  - If in_valid[k] drops while locked, the lock still holds; no other channel is granted.
  - Reset clears the lock.
- Not defined: no in_last port; arbitration is re-evaluated on every beat as described above.

Decomposition:
- Shared package arb_mux_pkg holds:
  - the clog2-based SELW helper function;
  - the constant ARB_MUX_MAX_N = 16.
- One sub-module, rr_arbiter:
  - inputs: req[N-1:0], ptr[SELW-1:0];
  - outputs: one-hot grant[N-1:0] and the encoded grant index;
  - purely combinational, implemented as a double-width masked priority search.
- The pointer register, the lock state and the output register stay in arb_mux.

Test Plan:
- Reset: hold rst high for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
- Round-robin: N=4, all four channels valid with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, data matching.
- Backpressure: out_ready=0 for 3 cycles after the beat from channel 2 loads -> out_data stays 0xA2, in_ready=0; on release the next grant is channel 3.
- Sparse requests: only channels 1 and 3 valid, pointer=2 -> channel 3 granted first, then channel 1; idle cycles give out_valid=0.
- Simultaneous drain and load: out_valid=1 and out_ready=1 while channel 0 requests -> new beat loaded on the same edge, out_valid stays 1, no bubble.
- Lock (ARB_MUX_LOCK_EN defined): channel 1 sends 3 beats with in_last=0,0,1 while channel 0 requests -> out_sel=1,1,1, then 0.
